// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer slice.
//   ALU_W       : default operand/result width of the ALU16b datapath.
//   OP_*        : three-bit op codes understood by the ALU.
//   seq_state_t : sequencer FSM states.
//   is_legal_op : true for the five op codes the ALU implements.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } seq_state_t;

    // Codes 001, 011 and 110 have no ALU function behind them.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Command and response channels of the ALU operation sequencer.
//   Command  : CmdValid/CmdReady handshake carrying CmdOp, CmdA, CmdB.
//   Response : RspValid/RspReady handshake carrying RspData, RspOp, RspErr.
// Modports:
//   master : the datapath control that issues commands and consumes results.
//   slave  : the sequencer itself.
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16
);

    logic             CmdValid;
    logic             CmdReady;
    logic [2:0]       CmdOp;
    logic [WIDTH-1:0] CmdA;
    logic [WIDTH-1:0] CmdB;

    logic             RspValid;
    logic             RspReady;
    logic [WIDTH-1:0] RspData;
    logic [2:0]       RspOp;
    logic             RspErr;

    modport master (
        output CmdValid, CmdOp, CmdA, CmdB, RspReady,
        input  CmdReady, RspValid, RspData, RspOp, RspErr
    );

    modport slave (
        input  CmdValid, CmdOp, CmdA, CmdB, RspReady,
        output CmdReady, RspValid, RspData, RspOp, RspErr
    );

endinterface

// File: rtl/alu_golden_model.sv
// ---------------------------------------------------------------------------
// alu_golden_model
// Combinational reference of the ALU16b function, used to cross-check the
// real ALU result when the sequencer is built with checking enabled.
// Ports:
//   a, b     : latched operands (ALUSrcA / ALUSrcB)
//   op       : latched op code
//   expected : result the ALU should produce (0 for illegal codes)
// ---------------------------------------------------------------------------
module alu_golden_model
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] expected
);

    // SUB and SLT take B as the left-hand operand, matching the ALU wiring.
    always_comb begin
        expected = '0;
        case (op)
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_ADD:  expected = a + b;
            OP_SUB:  expected = b - a;
            OP_SLT:  expected = {{(WIDTH-1){1'b0}}, (b < a)};
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Clocked initiator in front of the combinational ALU16b. Accepts one command
// per handshake, drives registered operands to the ALU, holds them for
// SETTLE_CYCLES cycles, samples R and returns it on the response channel.
// Ports:
//   CLK, Reset         : clock (rising edge), synchronous active-high reset
//   bus (slave)        : command and response channels
//   ALUSrcA/ALUSrcB/Op : registered operands and op select to the ALU
//   R                  : ALU result
//   OpCount            : legal responses delivered (wraps)
//   RspMismatch        : ALU result disagreed with the golden model
//   MismatchCount      : mismatches seen, saturating at FF
// Build option:
//   ALU_CHECK_EN       : when defined, a golden model checks R at capture
//                        time; otherwise RspMismatch/MismatchCount read 0.
// ---------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                Reset,
    alu_op_sequencer_if.slave   bus,
    output logic [WIDTH-1:0]    ALUSrcA,
    output logic [WIDTH-1:0]    ALUSrcB,
    output logic [2:0]          Op,
    input  logic [WIDTH-1:0]    R,
    output logic [15:0]         OpCount,
    output logic                RspMismatch,
    output logic [7:0]          MismatchCount
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       stateNext;
    seq_state_t       acceptState;
    logic [3:0]       settleCnt;
    logic [3:0]       settleCntNext;
    logic             cmdLegal;
    logic             cmdAccept;
    logic             rspHandshake;
    logic [WIDTH-1:0] rspData;
    logic [2:0]       rspOp;
    logic             rspErr;

    // Handshake outputs are forced low while Reset is asserted so nothing is
    // offered or accepted during the reset cycle itself.
    assign bus.CmdReady = !Reset && ((state == IDLE) || ((state == RESP) && bus.RspReady));
    assign bus.RspValid = !Reset && (state == RESP);
    assign bus.RspData  = rspData;
    assign bus.RspOp    = rspOp;
    assign bus.RspErr   = rspErr;

    assign cmdLegal     = is_legal_op(bus.CmdOp);
    assign cmdAccept    = bus.CmdValid && bus.CmdReady;
    assign rspHandshake = (state == RESP) && bus.RspReady;

    // Next-state logic. The settle counter holds the number of settle cycles
    // still to run after the current one; CAPTURE is itself the last cycle
    // the operands are held, so R is sampled after exactly SETTLE_CYCLES
    // cycles of stable operands and a single-cycle settle skips SETTLE.
    always_comb begin
        stateNext     = state;
        settleCntNext = settleCnt;
        if (!cmdLegal) begin
            acceptState = RESP;
        end else if (SETTLE_CYCLES == 1) begin
            acceptState = CAPTURE;
        end else begin
            acceptState = SETTLE;
        end
        case (state)
            IDLE: begin
                if (cmdAccept) begin
                    stateNext     = acceptState;
                    settleCntNext = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                settleCntNext = settleCnt - 4'd1;
                if (settleCnt == 4'd1) begin
                    stateNext = CAPTURE;
                end
            end
            CAPTURE: begin
                stateNext = RESP;
            end
            RESP: begin
                if (rspHandshake) begin
                    if (cmdAccept) begin
                        stateNext     = acceptState;
                        settleCntNext = SETTLE_LOAD;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, ALU operand and response registers. ALU operands only change on
    // a legal accept so an illegal code never reaches the ALU. The response
    // is loaded either from R at capture or as an error response directly on
    // an illegal accept, and is then held until the handshake.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            settleCnt <= '0;
            ALUSrcA   <= '0;
            ALUSrcB   <= '0;
            Op        <= '0;
            rspData   <= '0;
            rspOp     <= '0;
            rspErr    <= 1'b0;
            OpCount   <= '0;
        end else begin
            state     <= stateNext;
            settleCnt <= settleCntNext;
            if (cmdAccept && cmdLegal) begin
                ALUSrcA <= bus.CmdA;
                ALUSrcB <= bus.CmdB;
                Op      <= bus.CmdOp;
            end
            if (state == CAPTURE) begin
                rspData <= R;
                rspOp   <= Op;
                rspErr  <= 1'b0;
            end else if (cmdAccept && !cmdLegal) begin
                rspData <= '0;
                rspOp   <= bus.CmdOp;
                rspErr  <= 1'b1;
            end
            if (rspHandshake && !rspErr) begin
                OpCount <= OpCount + 16'd1;
            end
        end
    end

`ifdef ALU_CHECK_EN
    logic [WIDTH-1:0] goldenResult;
    logic             resultBad;

    alu_golden_model #(
        .WIDTH (WIDTH)
    ) uGolden (
        .a        (ALUSrcA),
        .b        (ALUSrcB),
        .op       (Op),
        .expected (goldenResult)
    );

    assign resultBad = (goldenResult != R);

    // The mismatch flag travels with the response it belongs to: set at
    // capture, cleared when that response is taken. The counter saturates.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            RspMismatch   <= 1'b0;
            MismatchCount <= '0;
        end else if (state == CAPTURE) begin
            RspMismatch <= resultBad;
            if (resultBad && (MismatchCount != 8'hFF)) begin
                MismatchCount <= MismatchCount + 8'd1;
            end
        end else if (rspHandshake) begin
            RspMismatch <= 1'b0;
        end
    end
`else
    assign RspMismatch   = 1'b0;
    assign MismatchCount = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Bench for alu_op_sequencer. Acts as both the command master and the ALU
// (R is computed from the DUT's ALU outputs), keeps a response-queue model
// of what the sequencer must deliver, compares every cycle, and adds
// directed checks with hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int W  = 16;
    localparam int SC = 2;

`ifdef ALU_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [2:0]  op;
        logic        err;
        logic        mism;
        int          validFrom;
    } rsp_t;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [W-1:0]  ALUSrcA;
    logic [W-1:0]  ALUSrcB;
    logic [2:0]    Op;
    logic [W-1:0]  R;
    logic [15:0]   OpCount;
    logic          RspMismatch;
    logic [7:0]    MismatchCount;
    logic          forceRZero = 1'b0;

    int            vectors = 0;
    int            miscompares = 0;
    int            cycle = 0;

    rsp_t          q[$];
    rsp_t          e;
    logic [15:0]   mA = '0;
    logic [15:0]   mB = '0;
    logic [2:0]    mOp = '0;
    logic [15:0]   mCount = '0;
    logic [7:0]    mMism = '0;
    bit            hsM;
    bit            accM;
    bit            expReady;

    logic [15:0]   logData[$];
    logic          logErr[$];
    logic [15:0]   expLogData [8] = '{16'h0002, 16'hFFFF, 16'h0007, 16'h8888,
                                      16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
    logic          expLogErr  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    alu_op_sequencer_if #(.WIDTH(W)) bus();

    alu_op_sequencer #(
        .WIDTH         (W),
        .SETTLE_CYCLES (SC)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .bus           (bus),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .Op            (Op),
        .R             (R),
        .OpCount       (OpCount),
        .RspMismatch   (RspMismatch),
        .MismatchCount (MismatchCount)
    );

    always #5 CLK = ~CLK;

    // The ALU16b function as documented for the datapath.
    function automatic logic [15:0] aluRef(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'b000:  return a & b;
            3'b010:  return a | b;
            3'b100:  return a + b;
            3'b101:  return b - a;
            3'b111:  return (b < a) ? 16'd1 : 16'd0;
            default: return 16'hDEAD;
        endcase
    endfunction

    function automatic bit legalOp(input logic [2:0] op);
        return op inside {3'b000, 3'b010, 3'b100, 3'b101, 3'b111};
    endfunction

    function automatic bit expValid();
        return (q.size() > 0) && (q[0].validFrom <= cycle);
    endfunction

    assign R = forceRZero ? '0 : aluRef(Op, ALUSrcA, ALUSrcB);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference model: on every rising edge, decide from the handshake rules
    // which response is taken and which command is accepted, and queue the
    // response the command must produce with the cycle it becomes visible.
    initial forever begin
        @(posedge CLK);
        if (Reset) begin
            q.delete();
            mA     = '0;
            mB     = '0;
            mOp    = '0;
            mCount = '0;
            mMism  = '0;
        end else begin
            hsM  = expValid() && bus.RspReady;
            accM = bus.CmdValid && ((q.size() == 0) || hsM);
            if (hsM) begin
                if (!q[0].err) mCount = mCount + 16'd1;
                void'(q.pop_front());
            end
            if (accM) begin
                e.op = bus.CmdOp;
                if (legalOp(bus.CmdOp)) begin
                    e.data      = forceRZero ? 16'h0000 : aluRef(bus.CmdOp, bus.CmdA, bus.CmdB);
                    e.err       = 1'b0;
                    e.mism      = CHECK_ON && forceRZero && (aluRef(bus.CmdOp, bus.CmdA, bus.CmdB) != 16'h0000);
                    e.validFrom = cycle + SC + 1;
                    mA  = bus.CmdA;
                    mB  = bus.CmdB;
                    mOp = bus.CmdOp;
                end else begin
                    e.data      = 16'h0000;
                    e.err       = 1'b1;
                    e.mism      = 1'b0;
                    e.validFrom = cycle + 1;
                end
                q.push_back(e);
            end
            if ((q.size() > 0) && (q[0].validFrom == cycle + 1) && q[0].mism && (mMism != 8'hFF)) begin
                mMism = mMism + 8'd1;
            end
        end
        cycle++;
    end

    // Compare process: every falling edge, check all DUT outputs against the
    // model. While Reset is high only the gated handshake outputs are known.
    initial forever begin
        @(negedge CLK);
        expReady = !Reset && ((q.size() == 0) || (expValid() && bus.RspReady));
        checkOutput("CmdReady", 32'(bus.CmdReady), 32'(expReady));
        checkOutput("RspValid", 32'(bus.RspValid), 32'(!Reset && expValid()));
        if (!Reset) begin
            if (expValid()) begin
                checkOutput("RspData", 32'(bus.RspData), 32'(q[0].data));
                checkOutput("RspOp", 32'(bus.RspOp), 32'(q[0].op));
                checkOutput("RspErr", 32'(bus.RspErr), 32'(q[0].err));
                checkOutput("RspMismatch", 32'(RspMismatch), 32'(q[0].mism));
            end else begin
                checkOutput("RspMismatchIdle", 32'(RspMismatch), 32'h0);
            end
            checkOutput("OpCount", 32'(OpCount), 32'(mCount));
            checkOutput("ALUSrcA", 32'(ALUSrcA), 32'(mA));
            checkOutput("ALUSrcB", 32'(ALUSrcB), 32'(mB));
            checkOutput("Op", 32'(Op), 32'(mOp));
            checkOutput("MismatchCount", 32'(MismatchCount), 32'(mMism));
        end
    end

    // Response log of every completed handshake, checked against literals.
    initial forever begin
        @(negedge CLK);
        if (!Reset && bus.RspValid && bus.RspReady) begin
            logData.push_back(bus.RspData);
            logErr.push_back(bus.RspErr);
        end
    end

    // Safety net so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Offer a command (caller is just after a rising edge) and wait for it to
    // be accepted; returns the accept cycle and leaves CmdValid low.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, output int acc);
        bit done;
        done         = 1'b0;
        acc          = -1;
        bus.CmdValid = 1'b1;
        bus.CmdOp    = op;
        bus.CmdA     = a;
        bus.CmdB     = b;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (bus.CmdReady) begin
                acc  = cycle;
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
        end
        bus.CmdValid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL acceptTimeout: got no CmdReady, expected accept of op %0b", op);
        end
    endtask

    // Wait (bounded) for RspValid; returns at that falling edge.
    task automatic waitValid(output int vc);
        vc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.RspValid) begin
                vc = cycle;
                break;
            end
        end
        if (vc < 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rspTimeout: got no RspValid, expected a response");
        end
    endtask

    task automatic nextEdge();
        @(posedge CLK);
        #1;
    endtask

    int acc;
    int a1;
    int a2;
    int a3;
    int vc;
    int nLoop;

    initial begin
        Reset        = 1'b1;
        bus.CmdValid = 1'b0;
        bus.CmdOp    = '0;
        bus.CmdA     = '0;
        bus.CmdB     = '0;
        bus.RspReady = 1'b0;

        nextEdge();
        @(negedge CLK);
        checkOutput("rstCmdReady", 32'(bus.CmdReady), 32'h0);
        nextEdge();
        Reset        = 1'b0;
        bus.RspReady = 1'b1;
        @(negedge CLK);
        checkOutput("rstALUSrcA", 32'(ALUSrcA), 32'h0);
        checkOutput("rstOpCount", 32'(OpCount), 32'h0);
        checkOutput("rstRspValid", 32'(bus.RspValid), 32'h0);
        checkOutput("idleCmdReady", 32'(bus.CmdReady), 32'h1);

        // ADD timing
        nextEdge();
        applyStimulus(3'b100, 16'h0001, 16'h0001, acc);
        @(negedge CLK);
        checkOutput("addSrcA", 32'(ALUSrcA), 32'h1);
        checkOutput("addOp", 32'(Op), 32'h4);
        waitValid(vc);
        checkOutput("addLatency", 32'(vc), 32'(acc + 3));
        checkOutput("addData", 32'(bus.RspData), 32'h2);
        nextEdge();
        @(negedge CLK);
        checkOutput("addOpCount", 32'(OpCount), 32'h1);

        // SUB under backpressure
        nextEdge();
        bus.RspReady = 1'b0;
        applyStimulus(3'b101, 16'h0002, 16'h0001, acc);
        waitValid(vc);
        checkOutput("subData", 32'(bus.RspData), 32'hFFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checkOutput("subHoldValid", 32'(bus.RspValid), 32'h1);
            checkOutput("subHoldData", 32'(bus.RspData), 32'hFFFF);
            checkOutput("subHoldReady", 32'(bus.CmdReady), 32'h0);
        end
        nextEdge();
        bus.RspReady = 1'b1;
        nextEdge();
        @(negedge CLK);
        checkOutput("subDrop", 32'(bus.RspValid), 32'h0);
        checkOutput("subOpCount", 32'(OpCount), 32'h2);

        // Back-to-back commands accepted on the response handshake
        nextEdge();
        applyStimulus(3'b100, 16'h0003, 16'h0004, a1);
        applyStimulus(3'b000, 16'hFFFF, 16'h8888, a2);
        applyStimulus(3'b010, 16'hEEEE, 16'h1111, a3);
        checkOutput("b2bGapAnd", 32'(a2), 32'(a1 + 3));
        checkOutput("b2bGapOr", 32'(a3), 32'(a2 + 3));
        waitValid(vc);
        checkOutput("orData", 32'(bus.RspData), 32'hFFFF);

        // Illegal op code
        nextEdge();
        applyStimulus(3'b110, 16'h1234, 16'h5678, acc);
        @(negedge CLK);
        checkOutput("illValid", 32'(bus.RspValid), 32'h1);
        checkOutput("illErr", 32'(bus.RspErr), 32'h1);
        checkOutput("illData", 32'(bus.RspData), 32'h0);
        checkOutput("illRspOp", 32'(bus.RspOp), 32'h6);
        checkOutput("illSrcA", 32'(ALUSrcA), 32'hEEEE);
        checkOutput("illSrcB", 32'(ALUSrcB), 32'h1111);
        checkOutput("illOp", 32'(Op), 32'h2);
        nextEdge();
        @(negedge CLK);
        checkOutput("illOpCount", 32'(OpCount), 32'h5);

        // SLT
        nextEdge();
        applyStimulus(3'b111, 16'h0001, 16'h0000, acc);
        waitValid(vc);
        checkOutput("sltTrue", 32'(bus.RspData), 32'h1);
        nextEdge();
        applyStimulus(3'b111, 16'h0000, 16'hFFFF, acc);
        waitValid(vc);
        checkOutput("sltFalse", 32'(bus.RspData), 32'h0);

        // Reset during SETTLE aborts the command
        nextEdge();
        applyStimulus(3'b100, 16'h0005, 16'h0006, acc);
        Reset = 1'b1;
        nextEdge();
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checkOutput("abortNoRsp", 32'(bus.RspValid), 32'h0);
        end
        checkOutput("abortSrcA", 32'(ALUSrcA), 32'h0);
        checkOutput("abortOp", 32'(Op), 32'h0);
        checkOutput("abortOpCount", 32'(OpCount), 32'h0);
        checkOutput("abortRspData", 32'(bus.RspData), 32'h0);

        // Golden-model check with R forced to zero
        nextEdge();
        forceRZero = 1'b1;
        nLoop = CHECK_ON ? 300 : 3;
        for (int i = 0; i < nLoop; i++) begin
            applyStimulus(3'b100, 16'h0001, 16'h0001, acc);
            waitValid(vc);
            if (i == 0) begin
                checkOutput("chkFirstMism", 32'(RspMismatch), CHECK_ON ? 32'h1 : 32'h0);
                checkOutput("chkFirstCount", 32'(MismatchCount), CHECK_ON ? 32'h1 : 32'h0);
            end
            nextEdge();
        end
        @(negedge CLK);
        checkOutput("chkSatCount", 32'(MismatchCount), CHECK_ON ? 32'hFF : 32'h0);
        nextEdge();
        forceRZero = 1'b0;

        // Delivered responses in order
        checkOutput("logSize", 32'(logData.size() >= 8), 32'h1);
        if (logData.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("logData%0d", i), 32'(logData[i]), 32'(expLogData[i]));
                checkOutput($sformatf("logErr%0d", i), 32'(logErr[i]), 32'(expLogErr[i]));
            end
        end

        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
